// File: rtl/i2s_sample_tx.sv
// Purpose     : I2S transmitter that sends one mono sample per frame on both slots, MSB-first.
// Latency     : a fetched sample's MSB appears on sdata_o at the same SCLK fall tick that fetches it.
// Backpressure: none; ready_o is a one-cycle request per frame, and a low valid_i repeats the old sample.
//
// Ports:
//   clk_i       system clock, rising edge
//   reset_n_i   asynchronous active-low reset
//   data_i      signed sample from the generator (width_p bits)
//   valid_i     data_i valid; only looked at while ready_o is high
//   ready_o     one-cycle fetch request, once per frame
//   sclk_o      I2S bit clock (clk_i / (2*clk_div_p))
//   lrclk_o     I2S word select, 0 = left, 1 = right
//   sdata_o     I2S serial data; changes on SCLK falling edges
//   underrun_o  one-cycle pulse when a fetch finds valid_i low
module i2s_sample_tx #(
  parameter int width_p      = 12,
  parameter int slot_width_p = 16,
  parameter int clk_div_p    = 4
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic [width_p-1:0] data_i,
  input  logic               valid_i,
  output logic               ready_o,
  output logic               sclk_o,
  output logic               lrclk_o,
  output logic               sdata_o,
  output logic               underrun_o
);

  localparam int frame_bits_lp = 2 * slot_width_p;
  localparam int bw_lp         = $clog2(frame_bits_lp);
  localparam int dw_lp         = (clk_div_p > 1) ? $clog2(clk_div_p) : 1;
  localparam int pw_lp         = (slot_width_p > 1) ? $clog2(slot_width_p) : 1;

  logic [dw_lp-1:0]        div_q, div_nxt;
  logic                    sclk_q;
  logic [bw_lp-1:0]        b_q, b_nxt;
  logic                    lrclk_q, lrclk_nxt;
  logic                    sdata_q, sdata_nxt;
  logic [width_p-1:0]      sample_q, sample_nxt;
  logic                    wrap;
  logic                    fall_tick;
  logic [bw_lp-1:0]        q_idx;
  logic [pw_lp-1:0]        pos;
  logic [slot_width_p-1:0] slot_bits;
  logic [slot_width_p-1:0] slot_shift;

  always_comb begin
    wrap       = (div_q == dw_lp'(clk_div_p - 1));
    div_nxt    = wrap ? '0 : div_q + dw_lp'(1);
    fall_tick  = wrap & sclk_q;

    // Fetch happens on the fall tick that moves b from 0 to 1.
    ready_o    = fall_tick & (b_q == '0);
    underrun_o = ready_o & ~valid_i;
    sample_nxt = (ready_o & valid_i) ? data_i : sample_q;

    b_nxt      = (b_q == bw_lp'(frame_bits_lp - 1)) ? '0 : b_q + bw_lp'(1);
    lrclk_nxt  = (b_nxt >= bw_lp'(slot_width_p));

    // One-bit delay: the bit shown at index b belongs to slot position (b-1) mod slot.
    q_idx      = (b_nxt == '0) ? bw_lp'(frame_bits_lp - 1) : b_nxt - bw_lp'(1);
    pos        = pw_lp'((q_idx >= bw_lp'(slot_width_p)) ? q_idx - bw_lp'(slot_width_p) : q_idx);

    // MSB-align the sample in the slot; pad positions shift in zeros.
    slot_bits  = slot_width_p'(sample_nxt) << (slot_width_p - width_p);
    slot_shift = slot_bits << pos;
    sdata_nxt  = slot_shift[slot_width_p-1];
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      div_q    <= '0;
      sclk_q   <= 1'b0;
      b_q      <= '0;
      lrclk_q  <= 1'b0;
      sdata_q  <= 1'b0;
      sample_q <= '0;
    end else begin
      div_q    <= div_nxt;
      sample_q <= sample_nxt;
      if (wrap) begin
        sclk_q <= ~sclk_q;
      end
      if (fall_tick) begin
        b_q     <= b_nxt;
        lrclk_q <= lrclk_nxt;
        sdata_q <= sdata_nxt;
      end
    end
  end

  assign sclk_o  = sclk_q;
  assign lrclk_o = lrclk_q;
  assign sdata_o = sdata_q;

endmodule

// File: tb/tb_i2s_sample_tx.sv
// Purpose     : bench for i2s_sample_tx; a padded-slot instance (16-bit slots) and an exact-fit instance (12-bit slots).
// Latency     : outputs compared every cycle against a frame-arithmetic reference model.
// Backpressure: the generator side is randomized, with directed values on the first fetches after each reset.
module tb_i2s_sample_tx;

  localparam int W  = 12;
  localparam int SA = 16;
  localparam int SB = 12;
  localparam int D  = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic [W-1:0] da, db;
  logic         va, vb;
  logic         rdy_a, sclk_a, lr_a, sd_a, un_a;
  logic         rdy_b, sclk_b, lr_b, sd_b, un_b;

  i2s_sample_tx #(.width_p(W), .slot_width_p(SA), .clk_div_p(D)) dut_a (
    .clk_i(clk), .reset_n_i(rst_n), .data_i(da), .valid_i(va), .ready_o(rdy_a),
    .sclk_o(sclk_a), .lrclk_o(lr_a), .sdata_o(sd_a), .underrun_o(un_a));

  i2s_sample_tx #(.width_p(W), .slot_width_p(SB), .clk_div_p(D)) dut_b (
    .clk_i(clk), .reset_n_i(rst_n), .data_i(db), .valid_i(vb), .ready_o(rdy_b),
    .sclk_o(sclk_b), .lrclk_o(lr_b), .sdata_o(sd_b), .underrun_o(un_b));

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state: clock edges since reset release and the sample each DUT should be sending.
  int           e;
  logic [W-1:0] cur_a, cur_b;
  logic [W-1:0] pa_d, pb_d;
  logic         pa_v, pb_v;
  int           fa, fb;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at t=%0t e=%0d: got %0h expected %0h", tag, $time, e, got, exp);
    end
  endtask

  // The cycle right after edge ee is a fetch cycle when it is cycle 2D + k*frame (1-based).
  function automatic bit is_fetch(input int s, input int ee);
    int c;
    c = ee + 1;
    return (c >= 2 * D) && (((c - 2 * D) % (4 * D * s)) == 0);
  endfunction

  function automatic logic exp_sdata(input int s, input logic [W-1:0] smp, input int b);
    int q;
    int pos;
    q   = (b + 2 * s - 1) % (2 * s);
    pos = q % s;
    return (pos < W) ? smp[W-1-pos] : 1'b0;
  endfunction

  task automatic check_all();
    int  k;
    int  ba;
    int  bb;
    bit  sc;
    k  = e / (2 * D);
    ba = k % (2 * SA);
    bb = k % (2 * SB);
    sc = ((e / D) % 2) == 1;
    check_eq("sclk_a",     32'(sclk_a), 32'(sc));
    check_eq("lrclk_a",    32'(lr_a),   32'(ba >= SA));
    check_eq("sdata_a",    32'(sd_a),   32'(exp_sdata(SA, cur_a, ba)));
    check_eq("ready_a",    32'(rdy_a),  32'(is_fetch(SA, e)));
    check_eq("underrun_a", 32'(un_a),   32'(is_fetch(SA, e) && !va));
    check_eq("sclk_b",     32'(sclk_b), 32'(sc));
    check_eq("lrclk_b",    32'(lr_b),   32'(bb >= SB));
    check_eq("sdata_b",    32'(sd_b),   32'(exp_sdata(SB, cur_b, bb)));
    check_eq("ready_b",    32'(rdy_b),  32'(is_fetch(SB, e)));
    check_eq("underrun_b", 32'(un_b),   32'(is_fetch(SB, e) && !vb));
  endtask

  task automatic check_zero(input string phase);
    check_eq({phase, "_out_a"}, {28'd0, rdy_a, sclk_a, lr_a, sd_a}, 32'd0);
    check_eq({phase, "_un_a"},  32'(un_a), 32'd0);
    check_eq({phase, "_out_b"}, {28'd0, rdy_b, sclk_b, lr_b, sd_b}, 32'd0);
    check_eq({phase, "_un_b"},  32'(un_b), 32'd0);
  endtask

  // Drive the generator inputs for the cycle following edge e.
  task automatic drive_inputs();
    da = W'($urandom);
    va = 1'($urandom_range(0, 1));
    if (is_fetch(SA, e)) begin
      case (fa)
        0:       begin va = 1'b1; da = 12'h7FF; end
        1:       begin va = 1'b0; end
        2:       begin va = 1'b1; da = 12'h800; end
        3:       begin va = 1'b1; da = 12'h001; end
        default: va = ($urandom_range(0, 3) != 0);
      endcase
      fa++;
    end
    db = W'($urandom);
    vb = 1'($urandom_range(0, 1));
    if (is_fetch(SB, e)) begin
      vb = 1'b1;
      db = (fb % 2 == 0) ? 12'hFFF : 12'h000;
      fb++;
    end
    pa_d = da; pa_v = va;
    pb_d = db; pb_v = vb;
  endtask

  // Release reset just after a rising edge and check the first cycle.
  task automatic release_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    e     = 0;
    cur_a = '0;
    cur_b = '0;
    fa    = 0;
    fb    = 0;
    drive_inputs();
    #1;
    check_all();
  endtask

  task automatic run_cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      e++;
      if (is_fetch(SA, e - 1) && pa_v) cur_a = pa_d;
      if (is_fetch(SB, e - 1) && pb_v) cur_b = pb_d;
      #1;
      drive_inputs();
      #1;
      check_all();
    end
  endtask

  initial begin
    rst_n = 1'b0;
    da = '0; db = '0; va = 1'b0; vb = 1'b0;
    pa_d = '0; pb_d = '0; pa_v = 1'b0; pb_v = 1'b0;
    e = 0; cur_a = '0; cur_b = '0; fa = 0; fb = 0;

    repeat (5) begin
      @(posedge clk);
      #2;
      check_zero("reset");
    end

    release_reset();
    run_cycles(8 * 4 * D * SA);

    // Advance until the padded instance sits at b = 20, then reset between clock edges.
    run_cycles((4 * D * SA) - (e % (4 * D * SA)) + 20 * 2 * D);
    check_eq("pre_reset_b", 32'((e / (2 * D)) % (2 * SA)), 32'd20);
    #1;
    rst_n = 1'b0;
    #1;
    check_zero("async_reset");
    repeat (3) begin
      @(posedge clk);
      #2;
      check_zero("held_reset");
    end

    release_reset();
    run_cycles(5 * 4 * D * SA);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
